// File: rtl/run_controller.sv
// run_controller
//
// Sequences one run of a small cluster of processor cores:
//   IDLE  -> waits for start; latches mode/target/timeout and clears the
//            per-run counters.
//   RESET -> holds every core in reset for RST_CYCLES cycles.
//   RUN   -> enables the cores and counts cycles and retired instructions
//            until an end condition fires.
//   DONE  -> one-cycle completion pulse, then back to IDLE.
//
// Handshake: start is a level request that is only looked at in IDLE; one
// cycle with start=1 in IDLE is accepted, start in any other state is
// dropped. done is a one-cycle pulse with status/cycles/retired valid in
// that cycle; those values then hold until the next accepted start.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start                 run request (IDLE only)
//   mode[1:0]             0 fixed cycles, 1 retired count, 2/3 until halt
//   target[CNT_W-1:0]     cycle or instruction target
//   timeout[CNT_W-1:0]    RUN cycle limit, 0 disables it
//   retire[N_CORES-1:0]   per-core instruction-retired strobe
//   halt[N_CORES-1:0]     per-core halt indication
//   abort                 synchronous run abort (RESET and RUN only)
//   core_reset_n          active-low reset to each core
//   core_en               core clock enable, high only in RUN
//   busy                  high in RESET, RUN and DONE
//   done                  completion pulse
//   status[1:0]           end cause: 00 target, 01 halt, 10 timeout, 11 abort
//   cycles, retired       RUN cycles / retired instructions of the run
//   dbg_state[1:0]        current FSM state (0 IDLE, 1 RESET, 2 RUN, 3 DONE)

module run_controller #(
    parameter int CNT_W      = 32,
    parameter int N_CORES    = 1,
    parameter int RST_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   target,
    input  logic [CNT_W-1:0]   timeout,
    input  logic [N_CORES-1:0] retire,
    input  logic [N_CORES-1:0] halt,
    input  logic               abort,
    output logic [N_CORES-1:0] core_reset_n,
    output logic               core_en,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic [CNT_W-1:0]   cycles,
    output logic [CNT_W-1:0]   retired,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] ST_TARGET  = 2'b00;
    localparam logic [1:0] ST_HALT    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         r_mode;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_timeout;
    logic [RCW-1:0]     r_rst_cnt;
    logic [CNT_W-1:0]   r_cycles;
    logic [CNT_W-1:0]   r_retired;
    logic [N_CORES-1:0] r_halt_sticky;
    logic [1:0]         r_status;
    // Set once the first run has left RESET; releases core reset in IDLE.
    logic               r_ran;

    logic [CNT_W:0]     w_pop;
    logic [CNT_W:0]     w_ret_sum;
    logic [CNT_W:0]     w_cyc_sum;
    logic [CNT_W-1:0]   w_retired_next;
    logic [CNT_W-1:0]   w_cycles_next;
    logic               w_halt_all;
    logic               w_target_hit;
    logic               w_timeout_hit;
    logic               w_end;
    logic [1:0]         w_end_status;

    // Popcount of retire, computed one bit wider than the counter so the
    // saturating add below can see the carry.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_CORES; i++) begin
            w_pop = w_pop + (CNT_W+1)'(retire[i]);
        end
    end

    assign w_ret_sum      = {1'b0, r_retired} + w_pop;
    assign w_retired_next = w_ret_sum[CNT_W] ? '1 : w_ret_sum[CNT_W-1:0];
    assign w_cyc_sum      = {1'b0, r_cycles} + (CNT_W+1)'(1);
    assign w_cycles_next  = w_cyc_sum[CNT_W] ? '1 : w_cyc_sum[CNT_W-1:0];

    // Halt includes this cycle's halt bits, not just the sticky history.
    assign w_halt_all    = &(r_halt_sticky | halt);
    assign w_timeout_hit = (r_timeout != '0) && (w_cycles_next == r_timeout);

    // Mode 3 is reserved and falls into the run-until-halt default.
    always_comb begin
        w_target_hit = 1'b0;
        case (r_mode)
            2'd0:    w_target_hit = (w_cycles_next == r_target);
            2'd1:    w_target_hit = (w_retired_next >= r_target);
            default: w_target_hit = 1'b0;
        endcase
    end

    // End-cause priority: abort > halt > target > timeout.
    always_comb begin
        w_end        = 1'b1;
        w_end_status = ST_TARGET;
        if (abort) begin
            w_end_status = ST_ABORT;
        end else if (w_halt_all) begin
            w_end_status = ST_HALT;
        end else if (w_target_hit) begin
            w_end_status = ST_TARGET;
        end else if (w_timeout_hit) begin
            w_end_status = ST_TIMEOUT;
        end else begin
            w_end = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_mode        <= '0;
            r_target      <= '0;
            r_timeout     <= '0;
            r_rst_cnt     <= '0;
            r_cycles      <= '0;
            r_retired     <= '0;
            r_halt_sticky <= '0;
            r_status      <= '0;
            r_ran         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_RESET;
                        r_mode        <= mode;
                        r_target      <= target;
                        r_timeout     <= timeout;
                        r_rst_cnt     <= '0;
                        r_cycles      <= '0;
                        r_retired     <= '0;
                        r_halt_sticky <= '0;
                        r_status      <= ST_TARGET;
                    end
                end
                S_RESET: begin
                    if (abort) begin
                        r_state  <= S_DONE;
                        r_status <= ST_ABORT;
                        r_ran    <= 1'b1;
                    end else if (r_rst_cnt == RST_LAST) begin
                        r_ran <= 1'b1;
                        // A zero target in the counting modes is already met.
                        if (!r_mode[1] && (r_target == '0)) begin
                            r_state  <= S_DONE;
                            r_status <= ST_TARGET;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RCW'(1);
                    end
                end
                S_RUN: begin
                    r_cycles      <= w_cycles_next;
                    r_retired     <= w_retired_next;
                    r_halt_sticky <= r_halt_sticky | halt;
                    if (w_end) begin
                        r_state  <= S_DONE;
                        r_status <= w_end_status;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        core_reset_n = '0;
        case (r_state)
            S_IDLE:  core_reset_n = r_ran ? '1 : '0;
            S_RESET: core_reset_n = '0;
            default: core_reset_n = '1;
        endcase
    end

    assign core_en   = (r_state == S_RUN);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign status    = r_status;
    assign cycles    = r_cycles;
    assign retired   = r_retired;
    assign dbg_state = r_state;

endmodule
